// File: rtl/xsim_sink_pkg.sv
// xsim_sink_pkg
// Shared types and helpers for the xsim message-sink scheduler.
//   beat_t       : one 32-bit indication beat
//   sched_state_t: scheduler FSM encoding
//   EMPTY_BEAT   : value presented on a lane whose FIFO is empty
//   unpack_dpi() : splits the longint returned by dpi_msgSink_beat into
//                  {valid, data}; bit 32 is valid, bits 63:33 are ignored
package xsim_sink_pkg;

    typedef logic [31:0] beat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } sched_state_t;

    localparam beat_t EMPTY_BEAT = 32'haaaaaaaa;

    typedef struct packed {
        logic  valid;
        beat_t data;
    } dpi_beat_t;

    function automatic dpi_beat_t unpack_dpi(input longint raw);
        dpi_beat_t r;
        r.valid = raw[32];
        r.data  = raw[31:0];
        return r;
    endfunction

endpackage

// File: rtl/xsim_sink_fifo.sv
// xsim_sink_fifo
// Per-portal beat FIFO. DEPTH must be a power of two so the pointers wrap
// naturally. The caller never enqueues when full nor dequeues when empty.
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   enq_i       : push enq_data_i
//   enq_data_i  : beat to push
//   deq_i       : pop the head
//   count_o     : number of beats held
//   head_o      : oldest beat, EMPTY_BEAT when empty
module xsim_sink_fifo
    import xsim_sink_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          enq_i,
    input  beat_t         enq_data_i,
    input  logic          deq_i,
    output logic [CW-1:0] count_o,
    output beat_t         head_o
);

    beat_t         mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq_i) begin
                mem_q[wr_ptr_q] <= enq_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (deq_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // simultaneous push and pop leaves the occupancy unchanged
            if (enq_i && !deq_i) begin
                count_q <= count_q + CW'(1);
            end else if (!enq_i && deq_i) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q == '0) ? EMPTY_BEAT : mem_q[rd_ptr_q];

endmodule

// File: rtl/xsim_sink_scheduler.sv
// xsim_sink_scheduler
// Shares the single dpi_msgSink_beat poll path among NUM_PORTALS portal
// indication channels: round-robin over eligible portals, at most one poll
// per cycle, per-portal FIFO buffering and RDY/EN delivery.
// The DPI call itself is made by the xsim wrapper: when dpi_call_o is high it
// evaluates dpi_msgSink_beat(dpi_portal_o) once and returns the longint on
// dpi_ret_i in the same cycle, keeping this core synthesizable.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   enable        : global poll enable
//   rdy_beat      : per-portal FIFO non-empty
//   en_beat       : per-portal dequeue strobe
//   beat          : per-portal FIFO head (lane i = bits 32*i+31:32*i)
//   busy          : scheduler not IDLE
//   err_underflow : sticky, dequeue attempted on an empty FIFO
//   poll_count    : DPI calls issued, wraps
//   dpi_call_o    : DPI call issued this cycle
//   dpi_portal_o  : portal index passed to the DPI call
//   dpi_ret_i     : longint returned by the DPI call
//
// state | meaning
// IDLE  | no polls, waiting for enable
// RUN   | polling one eligible portal per cycle
// STOP  | no polls, draining buffered beats
module xsim_sink_scheduler
    import xsim_sink_pkg::*;
#(
    parameter int NUM_PORTALS = 4,
    parameter int FIFO_DEPTH  = 2,
    parameter int BACKOFF     = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    output logic [NUM_PORTALS-1:0]    rdy_beat,
    input  logic [NUM_PORTALS-1:0]    en_beat,
    output logic [NUM_PORTALS*32-1:0] beat,
    output logic                      busy,
    output logic                      err_underflow,
    output logic [31:0]               poll_count,
    output logic                      dpi_call_o,
    output logic [31:0]               dpi_portal_o,
    input  logic [63:0]               dpi_ret_i
);

    localparam int PW = (NUM_PORTALS > 1) ? $clog2(NUM_PORTALS) : 1;
    localparam int BW = (BACKOFF > 0) ? $clog2(BACKOFF + 1) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    sched_state_t  state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] backoff_q [NUM_PORTALS];
    logic [BW-1:0] backoff_d [NUM_PORTALS];
    logic          err_q, err_d;
    logic [31:0]   poll_count_q, poll_count_d;

    logic [CW-1:0]          fifo_count [NUM_PORTALS];
    beat_t                  fifo_head  [NUM_PORTALS];
    logic [NUM_PORTALS-1:0] elig, enq, deq, drained;
    logic                   pick_found;
    logic [PW-1:0]          pick_idx, cand;
    logic                   poll;
    dpi_beat_t              resp;

    assign resp = unpack_dpi(dpi_ret_i);

    for (genvar g = 0; g < NUM_PORTALS; g++) begin : g_portal
        // occupancy is the registered count, so a same-cycle pop never frees a slot
        assign elig[g]     = (fifo_count[g] < CW'(FIFO_DEPTH)) && (backoff_q[g] == '0);
        assign enq[g]      = poll && resp.valid && (pick_idx == PW'(g));
        assign rdy_beat[g] = (fifo_count[g] != '0);
        assign deq[g]      = en_beat[g] && rdy_beat[g];
        // FIFO will be empty after this edge
        assign drained[g]  = (fifo_count[g] == '0) ||
                             ((fifo_count[g] == CW'(1)) && deq[g] && !enq[g]);
        assign beat[g*32 +: 32] = fifo_head[g];

        xsim_sink_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .CLK        (CLK),
            .RST        (RST),
            .enq_i      (enq[g]),
            .enq_data_i (resp.data),
            .deq_i      (deq[g]),
            .count_o    (fifo_count[g]),
            .head_o     (fifo_head[g])
        );
    end

    // first eligible portal at or after rr_ptr, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_PORTALS; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % NUM_PORTALS);
            if (!pick_found && elig[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign poll = (state_q == RUN) && pick_found;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable) state_d = RUN;
            RUN:  if (!enable) state_d = STOP;
            STOP: begin
                if (enable) begin
                    state_d = RUN;
                end else if (&drained) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d     = poll ? PW'((int'(pick_idx) + 1) % NUM_PORTALS) : rr_ptr_q;
        poll_count_d = poll ? poll_count_q + 32'd1 : poll_count_q;
        err_d        = err_q | (|(en_beat & ~rdy_beat));
        for (int i = 0; i < NUM_PORTALS; i++) begin
            backoff_d[i] = backoff_q[i];
            if (poll && (pick_idx == PW'(i))) begin
                backoff_d[i] = resp.valid ? '0 : BW'(BACKOFF);
            end else if (backoff_q[i] != '0) begin
                backoff_d[i] = backoff_q[i] - BW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            err_q        <= 1'b0;
            poll_count_q <= '0;
            for (int i = 0; i < NUM_PORTALS; i++) begin
                backoff_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            err_q        <= err_d;
            poll_count_q <= poll_count_d;
            for (int i = 0; i < NUM_PORTALS; i++) begin
                backoff_q[i] <= backoff_d[i];
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign err_underflow = err_q;
    assign poll_count    = poll_count_q;
    assign dpi_call_o    = poll;
    assign dpi_portal_o  = 32'(pick_idx);

endmodule

// File: tb/tb_xsim_sink_scheduler.sv
module tb_xsim_sink_scheduler;
    import xsim_sink_pkg::*;

    logic         CLK;
    logic         RST;
    logic         enable;
    logic [3:0]   rdy_beat;
    logic [3:0]   en_beat;
    logic [127:0] beat;
    logic         busy;
    logic         err_underflow;
    logic [31:0]  poll_count;
    logic         dpi_call;
    logic [31:0]  dpi_portal;
    logic [63:0]  dpi_ret;

    // DPI sink model: per-portal valid flag, base data plus a per-portal
    // count of valid beats already handed out
    logic [3:0]   resp_valid;
    logic [31:0]  resp_base [4];
    logic [31:0]  ofs [4];
    logic         ofs_clr;

    int n_cmp = 0;
    int n_err = 0;

    xsim_sink_scheduler #(
        .NUM_PORTALS (4),
        .FIFO_DEPTH  (2),
        .BACKOFF     (8)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .enable        (enable),
        .rdy_beat      (rdy_beat),
        .en_beat       (en_beat),
        .beat          (beat),
        .busy          (busy),
        .err_underflow (err_underflow),
        .poll_count    (poll_count),
        .dpi_call_o    (dpi_call),
        .dpi_portal_o  (dpi_portal),
        .dpi_ret_i     (dpi_ret)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // upper bits and invalid-data bits carry junk the DUT must ignore
    always_comb begin
        dpi_ret = {31'h2AD55A5A, 1'b0, 32'hDEAD0000};
        if (resp_valid[dpi_portal[1:0]]) begin
            dpi_ret = {31'h2AD55A5A, 1'b1, resp_base[dpi_portal[1:0]] + ofs[dpi_portal[1:0]]};
        end
    end

    always @(posedge CLK) begin
        if (ofs_clr) begin
            for (int i = 0; i < 4; i++) ofs[i] <= 32'd0;
        end else if (dpi_call && resp_valid[dpi_portal[1:0]]) begin
            ofs[dpi_portal[1:0]] <= ofs[dpi_portal[1:0]] + 32'd1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return beat[i*32 +: 32];
    endfunction

    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p1a, p1b;
        logic call8;
        logic [31:0] pc11;

        RST = 1'b1; enable = 1'b0; en_beat = 4'h0; resp_valid = 4'h0; ofs_clr = 1'b1;
        for (int i = 0; i < 4; i++) resp_base[i] = 32'h0;
        step();
        step();

        // reset state
        chk("rst_rdy", 64'(rdy_beat), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_beat%0d", i), 64'(lane(i)), 64'h00000000aaaaaaaa);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err", 64'(err_underflow), 0);
        chk("rst_pc", 64'(poll_count), 0);
        chk("rst_call", 64'(dpi_call), 0);

        // only portal 2 returns data; polls go 0,1,2,3
        RST = 1'b0; ofs_clr = 1'b0; enable = 1'b1; resp_valid = 4'b0100; resp_base[2] = 32'h11;
        step();
        chk("t1_busy", 64'(busy), 1);
        chk("t1_call", 64'(dpi_call), 1);
        chk("t1_port0", 64'(dpi_portal), 0);
        step();
        chk("t1_port1", 64'(dpi_portal), 1);
        step();
        chk("t1_port2", 64'(dpi_portal), 2);
        chk("t1_rdy2_early", 64'(rdy_beat[2]), 0);
        step();
        chk("t1_rdy2", 64'(rdy_beat[2]), 1);
        chk("t1_beat2", 64'(lane(2)), 64'h11);
        chk("t1_port3", 64'(dpi_portal), 3);
        chk("t1_pc", 64'(poll_count), 3);

        // reset in the middle of RUN
        RST = 1'b1; ofs_clr = 1'b1;
        step();
        chk("mrst_rdy", 64'(rdy_beat), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("mrst_beat%0d", i), 64'(lane(i)), 64'h00000000aaaaaaaa);
        chk("mrst_busy", 64'(busy), 0);
        chk("mrst_pc", 64'(poll_count), 0);
        chk("mrst_call", 64'(dpi_call), 0);

        // all portals valid, nothing consumed: eight polls fill every FIFO
        resp_valid = 4'hF;
        for (int i = 0; i < 4; i++) resp_base[i] = 32'hA0 + 32'h10 * 32'(i);
        RST = 1'b0; ofs_clr = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("t2_call%0d", c), 64'(dpi_call), 1);
            chk($sformatf("t2_order%0d", c), 64'(dpi_portal), 64'((c - 1) % 4));
        end
        step();
        chk("t2_nocall", 64'(dpi_call), 0);
        chk("t2_pc", 64'(poll_count), 8);
        chk("t2_rdy", 64'(rdy_beat), 64'hF);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_head%0d", i), 64'(lane(i)), 64'(32'hA0 + 32'h10 * 32'(i)));
        step();
        chk("t2_nocall2", 64'(dpi_call), 0);
        chk("t2_pc_hold", 64'(poll_count), 8);

        // continuous dequeue on portal 0: enqueue and dequeue overlap, order kept
        en_beat = 4'b0001;
        step();
        chk("t4_call1", 64'(dpi_call), 1);
        chk("t4_port1", 64'(dpi_portal), 0);
        chk("t4_head_a1", 64'(lane(0)), 64'hA1);
        step();
        chk("t4_port2", 64'(dpi_portal), 0);
        chk("t4_head_a2", 64'(lane(0)), 64'hA2);
        chk("t4_rdy0", 64'(rdy_beat[0]), 1);
        step();
        chk("t4_head_a3", 64'(lane(0)), 64'hA3);
        chk("t4_pc", 64'(poll_count), 10);
        en_beat = 4'h0;

        // portal 1 empty: next poll of portal 1 exactly BACKOFF+1 cycles later
        RST = 1'b1; enable = 1'b0; ofs_clr = 1'b1; resp_valid = 4'b1101;
        step();
        RST = 1'b0; ofs_clr = 1'b0; enable = 1'b1;
        p1a = 0; p1b = 0; call8 = 1'b1; pc11 = 32'hFFFFFFFF;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (dpi_call && dpi_portal == 32'd1) begin
                if (p1a == 0) p1a = c;
                else if (p1b == 0) p1b = c;
            end
            if (c == 8) call8 = dpi_call;
            if (c == 11) pc11 = poll_count;
        end
        chk("t3_p1_first", 64'(p1a), 2);
        chk("t3_p1_second", 64'(p1b), 11);
        chk("t3_idle_cycle", 64'(call8), 0);
        chk("t3_pc", 64'(pc11), 7);

        // three beats buffered, enable dropped, underflow on portal 3, drain
        RST = 1'b1; enable = 1'b0; ofs_clr = 1'b1; resp_valid = 4'b0111;
        step();
        RST = 1'b0; ofs_clr = 1'b0; enable = 1'b1;
        step();
        chk("t6_port0", 64'(dpi_portal), 0);
        step();
        chk("t6_port1", 64'(dpi_portal), 1);
        step();
        chk("t6_port2", 64'(dpi_portal), 2);
        enable = 1'b0;
        step();
        chk("t6_stop_busy", 64'(busy), 1);
        chk("t6_stop_nocall", 64'(dpi_call), 0);
        chk("t6_stop_rdy", 64'(rdy_beat), 64'h7);
        chk("t6_stop_pc", 64'(poll_count), 3);
        en_beat = 4'b1000;
        step();
        chk("t5_err", 64'(err_underflow), 1);
        chk("t5_rdy", 64'(rdy_beat), 64'h7);
        chk("t5_beat3", 64'(lane(3)), 64'h00000000aaaaaaaa);
        chk("t5_beat0", 64'(lane(0)), 64'hA0);
        chk("t5_pc", 64'(poll_count), 3);
        en_beat = 4'b0001;
        step();
        chk("t6_rdy_a", 64'(rdy_beat), 64'h6);
        chk("t6_busy_a", 64'(busy), 1);
        en_beat = 4'b0010;
        step();
        chk("t6_rdy_b", 64'(rdy_beat), 64'h4);
        chk("t6_busy_b", 64'(busy), 1);
        en_beat = 4'b0100;
        step();
        chk("t6_idle", 64'(busy), 0);
        chk("t6_rdy_c", 64'(rdy_beat), 0);
        chk("t5_err_sticky", 64'(err_underflow), 1);
        chk("t6_idle_nocall", 64'(dpi_call), 0);
        en_beat = 4'h0;
        RST = 1'b1;
        step();
        chk("t5_err_clr", 64'(err_underflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
